// File: rtl/f1_reaction_timer.sv
// f1_reaction_timer: lights-out to button-press reaction timer; optional best-time tracking via F1_TIMER_BEST_EN
module f1_reaction_timer #(
  parameter int CNT_W = 16,
  parameter logic [CNT_W-1:0] MAX_COUNT = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       lights,
  input  logic             btn,
  output logic [CNT_W-1:0] react_time,
  output logic             valid,
  output logic             jump_start,
  output logic             timeout,
  output logic             busy
`ifdef F1_TIMER_BEST_EN
  ,
  output logic [CNT_W-1:0] best_time
`endif
);
  typedef enum logic [1:0] {IDLE, ARMED, FULL, TIMING} state_t;
  state_t state_q;
  logic btn_q, valid_q, jump_q, to_q, busy_q;
  logic [CNT_W-1:0] cnt_q, react_q;
  logic press;
  logic [CNT_W-1:0] k;
  assign press = btn & ~btn_q;
  assign k = cnt_q + 1'b1;
  assign react_time = react_q;
  assign valid = valid_q;
  assign jump_start = jump_q;
  assign timeout = to_q;
  assign busy = busy_q;
`ifdef F1_TIMER_BEST_EN
  logic [CNT_W-1:0] best_q;
  assign best_time = best_q;
`endif
  // sequence FSM with registered result flags and reaction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      btn_q <= 1'b0;
      cnt_q <= '0;
      react_q <= '0;
      valid_q <= 1'b0;
      jump_q <= 1'b0;
      to_q <= 1'b0;
      busy_q <= 1'b0;
`ifdef F1_TIMER_BEST_EN
      best_q <= '1;
`endif
    end else begin
      btn_q <= btn;
      case (state_q)
        IDLE: if (lights == 8'h01) begin
          state_q <= ARMED;
          busy_q <= 1'b1;
          react_q <= '0;
          valid_q <= 1'b0;
          jump_q <= 1'b0;
          to_q <= 1'b0;
        end
        ARMED: if (press) begin
          state_q <= IDLE;
          busy_q <= 1'b0;
          jump_q <= 1'b1;
        end else if (lights == 8'hFF) begin
          state_q <= FULL;
        end else if (lights == 8'h00) begin
          state_q <= IDLE;
          busy_q <= 1'b0;
        end
        FULL: if (press) begin
          state_q <= IDLE;
          busy_q <= 1'b0;
          jump_q <= 1'b1;
        end else if (lights == 8'h00) begin
          state_q <= TIMING;
          cnt_q <= '0;
        end
        TIMING: begin
          cnt_q <= k;
          if (press) begin
            state_q <= IDLE;
            busy_q <= 1'b0;
            react_q <= k;
            valid_q <= 1'b1;
`ifdef F1_TIMER_BEST_EN
            if (k < best_q) best_q <= k;
`endif
          end else if (k == MAX_COUNT) begin
            state_q <= IDLE;
            busy_q <= 1'b0;
            react_q <= MAX_COUNT;
            to_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_f1_reaction_timer.sv
// tb_f1_reaction_timer: table-driven runs with a scoreboard of expected results
module tb_f1_reaction_timer;
  localparam int MAXC = 100;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] lights = 8'h00;
  logic btn = 1'b0;
  logic [15:0] react_time;
  logic valid, jump_start, timeout, busy;
`ifdef F1_TIMER_BEST_EN
  logic [15:0] best_time;
`endif
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    int kind;
    int arg;
    logic hold;
    logic [15:0] rt;
    logic v;
    logic j;
    logic t;
    logic [15:0] best;
  } run_t;
  run_t tbl [12];
  run_t exp_q [$];
  f1_reaction_timer #(.CNT_W(16), .MAX_COUNT(16'd100)) dut (
    .clk(clk),
    .rst(rst),
    .lights(lights),
    .btn(btn),
    .react_time(react_time),
    .valid(valid),
    .jump_start(jump_start),
    .timeout(timeout),
    .busy(busy)
`ifdef F1_TIMER_BEST_EN
    ,
    .best_time(best_time)
`endif
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] pat(input int i);
    pat = 8'hFF >> (7 - i);
  endfunction
  task automatic compare(input int idx);
    run_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk($sformatf("run%0d react_time", idx), 32'(react_time), 32'(e.rt));
    chk($sformatf("run%0d valid", idx), 32'(valid), 32'(e.v));
    chk($sformatf("run%0d jump_start", idx), 32'(jump_start), 32'(e.j));
    chk($sformatf("run%0d timeout", idx), 32'(timeout), 32'(e.t));
    chk($sformatf("run%0d busy", idx), 32'(busy), 32'd0);
`ifdef F1_TIMER_BEST_EN
    chk($sformatf("run%0d best_time", idx), 32'(best_time), 32'(e.best));
`endif
  endtask
  task automatic do_run(input int idx, input run_t r);
    bit done;
    done = 0;
    btn = r.hold;
    lights = 8'h00;
    tick();
    tick();
    exp_q.push_back(r);
    for (int i = 0; i < 8; i++) begin
      lights = pat(i);
      if (r.kind == 1 && r.arg == i) begin
        btn = 1'b1;
        tick();
        done = 1;
        break;
      end
      repeat (4) tick();
      if (i == 1) chk($sformatf("run%0d busy_armed", idx), 32'(busy), 32'd1);
      if (r.kind == 2 && r.arg == i) begin
        lights = 8'h00;
        tick();
        done = 1;
        break;
      end
    end
    if (!done) begin
      lights = 8'h00;
      if (r.kind == 1) begin
        btn = 1'b1;
        tick();
      end else begin
        tick();
        if (r.arg > 0) begin
          repeat (r.arg - 1) tick();
          btn = 1'b1;
        end else begin
          repeat (MAXC - 1) tick();
        end
        chk($sformatf("run%0d busy_timing", idx), 32'(busy), 32'd1);
        chk($sformatf("run%0d flags_while_busy", idx), 32'({valid, jump_start, timeout}), 32'd0);
        tick();
      end
    end
    compare(idx);
    btn = 1'b0;
    lights = 8'h00;
    tick();
    tick();
  endtask
  initial begin
    tbl[0]  = '{0, 25,  1'b0, 16'd25,  1'b1, 1'b0, 1'b0, 16'd25};
    tbl[1]  = '{1, 2,   1'b0, 16'd0,   1'b0, 1'b1, 1'b0, 16'd25};
    tbl[2]  = '{1, 8,   1'b0, 16'd0,   1'b0, 1'b1, 1'b0, 16'd25};
    tbl[3]  = '{0, 0,   1'b0, 16'd100, 1'b0, 1'b0, 1'b1, 16'd25};
    tbl[4]  = '{0, 100, 1'b0, 16'd100, 1'b1, 1'b0, 1'b0, 16'd25};
    tbl[5]  = '{0, 0,   1'b1, 16'd100, 1'b0, 1'b0, 1'b1, 16'd25};
    tbl[6]  = '{2, 1,   1'b0, 16'd0,   1'b0, 1'b0, 1'b0, 16'd25};
    tbl[7]  = '{0, 40,  1'b0, 16'd40,  1'b1, 1'b0, 1'b0, 16'd25};
    tbl[8]  = '{0, 50,  1'b0, 16'd50,  1'b1, 1'b0, 1'b0, 16'd50};
    tbl[9]  = '{0, 30,  1'b0, 16'd30,  1'b1, 1'b0, 1'b0, 16'd30};
    tbl[10] = '{0, 45,  1'b0, 16'd45,  1'b1, 1'b0, 1'b0, 16'd30};
    tbl[11] = '{1, 5,   1'b0, 16'd0,   1'b0, 1'b1, 1'b0, 16'd30};
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset react_time", 32'(react_time), 32'd0);
    chk("reset flags", 32'({valid, jump_start, timeout, busy}), 32'd0);
`ifdef F1_TIMER_BEST_EN
    chk("reset best_time", 32'(best_time), 32'hFFFF);
`endif
    for (int i = 0; i < 8; i++) do_run(i, tbl[i]);
    btn = 1'b1;
    tick();
    tick();
    btn = 1'b0;
    tick();
    chk("idle_press valid", 32'(valid), 32'd1);
    chk("idle_press react_time", 32'(react_time), 32'd40);
    chk("idle_press busy", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) begin
      lights = pat(i);
      repeat (4) tick();
    end
    lights = 8'h00;
    tick();
    repeat (9) tick();
    chk("pre_rst busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    chk("rst_mid react_time", 32'(react_time), 32'd0);
    chk("rst_mid flags", 32'({valid, jump_start, timeout, busy}), 32'd0);
`ifdef F1_TIMER_BEST_EN
    chk("rst_mid best_time", 32'(best_time), 32'hFFFF);
`endif
    rst = 1'b0;
    lights = 8'hFF;
    repeat (3) tick();
    chk("rst_mid idle", 32'(busy), 32'd0);
    lights = 8'h00;
    tick();
    for (int i = 8; i < 12; i++) do_run(i, tbl[i]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
